wb_retire_unit: RTL and testbench

Parametrised successor to the pipeline's write-back stage: accepts one instruction per cycle from MEM over a valid/ready handshake and holds memory ops until the data-memory response arrives, which may come any number of cycles later. It also aligns and extends load data for XLEN 32 or 64, and drives the register-file write port. On every retire it commits, advances the retire order, counts memory stall cycles, and traps misaligned accesses instead of writing back garbage.

---
 rtl/wb_retire_unit_pkg.sv | 62 ++++++
 rtl/wb_retire_unit_if.sv | 24 ++
 rtl/wb_retire_unit_load_align.sv | 37 +++
 rtl/wb_retire_unit.sv | 157 +++++++++++++++
 tb/tb_wb_retire_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_retire_unit_pkg.sv
// Shared types and decode helpers for the write-back / retire unit.
// Holds the write-source enum, FSM state and captured-instruction struct.
package wb_retire_unit_pkg;

  localparam logic [6:0] OP_B_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_B_STORE = 7'b0100011;

  typedef enum logic [3:0] {
    WB_ALU  = 4'd0,
    WB_BR   = 4'd1,
    WB_UIMM = 4'd2,
    WB_LINK = 4'd3,
    WB_LB   = 4'd4,
    WB_LBU  = 4'd5,
    WB_LH   = 4'd6,
    WB_LHU  = 4'd7,
    WB_LW   = 4'd8,
    WB_LWU  = 4'd9,
    WB_LD   = 4'd10
  } wb_sel_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    WAIT   = 2'd1,
    RETIRE = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic        regf_we;
    wb_sel_t     wbsel;
    logic [2:0]  addr_lo;
  } wb_hold_t;

  function automatic logic is_mem_op(input logic [6:0] opcode);
    return (opcode == OP_B_LOAD) || (opcode == OP_B_STORE);
  endfunction

  // Stores are word-sized; LWU/LD only exist on a 64-bit datapath.
  function automatic logic trap_check(input logic [6:0] opcode, input wb_sel_t wbsel,
                                      input logic [2:0] addr_lo, input logic xlen64);
    logic t;
    t = 1'b0;
    if (opcode == OP_B_STORE) begin
      t = (addr_lo[1:0] != 2'b00);
    end else if (opcode == OP_B_LOAD) begin
      case (wbsel)
        WB_LH, WB_LHU: t = addr_lo[0];
        WB_LW:         t = (addr_lo[1:0] != 2'b00);
        WB_LWU:        t = !xlen64 || (addr_lo[1:0] != 2'b00);
        WB_LD:         t = !xlen64 || (addr_lo != 3'b000);
        default:       t = 1'b0;
      endcase
    end else begin
      t = 1'b0;
    end
    return t;
  endfunction

endpackage

// File: rtl/wb_retire_unit_if.sv
// MEM -> write-back instruction handshake, one instruction per accepted cycle.
interface wb_retire_unit_if #(parameter int XLEN = 32);
  import wb_retire_unit_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_pc;
  logic [6:0]      in_opcode;
  logic [4:0]      in_rd;
  logic            in_regf_we;
  wb_sel_t         in_wbsel;
  logic [XLEN-1:0] in_result;
  logic [2:0]      in_addr_lo;

  modport master (
    output in_valid, in_pc, in_opcode, in_rd, in_regf_we, in_wbsel, in_result, in_addr_lo,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_opcode, in_rd, in_regf_we, in_wbsel, in_result, in_addr_lo,
    output in_ready
  );
endinterface

// File: rtl/wb_retire_unit_load_align.sv
// Combinational load extractor: shifts the addressed lane down and sign/zero extends.
module wb_load_align
  import wb_retire_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  wb_sel_t         wbsel,
  output logic [XLEN-1:0] data
);

  logic [2:0]      off_s;
  logic [XLEN-1:0] sh_s;

  // Byte offset only spans the datapath width; shift the addressed lane to bit 0.
  always_comb begin
    off_s = (XLEN == 64) ? offset : {1'b0, offset[1:0]};
    sh_s  = rdata >> {off_s, 3'b000};
  end

  // Select access size and extension.
  always_comb begin
    data = '0;
    case (wbsel)
      WB_LB:   data = XLEN'(signed'(sh_s[7:0]));
      WB_LBU:  data = XLEN'(sh_s[7:0]);
      WB_LH:   data = XLEN'(signed'(sh_s[15:0]));
      WB_LHU:  data = XLEN'(sh_s[15:0]);
      WB_LW:   data = XLEN'(signed'(sh_s[31:0]));
      WB_LWU:  data = XLEN'(sh_s[31:0]);
      WB_LD:   data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/wb_retire_unit.sv
// Write-back / retire stage: holds memory ops until the dmem response, aligns load
// data, drives the register-file port and keeps retire/stall/error bookkeeping.
module wb_retire_unit
  import wb_retire_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ORDER_W = 64,
  parameter int STALL_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  wb_retire_unit_if.slave    mem,
  input  logic               dmem_resp,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               rf_we,
  output logic [4:0]         rf_rd,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               commit,
  output logic [ORDER_W-1:0] order,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               trap_misalign,
  output logic               resp_err
);

  wb_state_t          state_r;
  wb_hold_t           hold_r;
  logic [XLEN-1:0]    result_r;
  logic               rf_we_r;
  logic [4:0]         rf_rd_r;
  logic [XLEN-1:0]    rf_wdata_r;
  logic               commit_r;
  logic               trap_r;
  logic [ORDER_W-1:0] order_r;
  logic [STALL_W-1:0] stall_r;
  logic               resp_err_r;

  wb_hold_t           in_hold_s;
  logic               accept_s;
  logic               in_trap_s;
  logic               in_wait_s;
  logic [XLEN-1:0]    align_s;
  logic               ret_go_s;
  logic               ret_trap_s;
  wb_hold_t           ret_hold_s;
  logic [XLEN-1:0]    ret_data_s;

  function automatic logic [XLEN-1:0] src_data(input wb_sel_t sel, input logic [XLEN-1:0] res,
                                               input logic [31:0] pc);
    logic [XLEN-1:0] d;
    case (sel)
      WB_BR:   d = XLEN'(res[0]);
      WB_LINK: d = XLEN'(pc + 32'd4);
      default: d = res;
    endcase
    return d;
  endfunction

  assign mem.in_ready = (state_r != WAIT);
  assign accept_s     = mem.in_valid && (state_r != WAIT);

  // Snapshot of the incoming instruction and its routing decision.
  always_comb begin
    in_hold_s.pc      = mem.in_pc;
    in_hold_s.opcode  = mem.in_opcode;
    in_hold_s.rd      = mem.in_rd;
    in_hold_s.regf_we = mem.in_regf_we;
    in_hold_s.wbsel   = mem.in_wbsel;
    in_hold_s.addr_lo = mem.in_addr_lo;
    in_trap_s = trap_check(mem.in_opcode, mem.in_wbsel, mem.in_addr_lo, (XLEN == 64));
    in_wait_s = is_mem_op(mem.in_opcode) && !in_trap_s;
  end

  wb_load_align #(.XLEN(XLEN)) u_align (
    .rdata  (dmem_rdata),
    .offset (hold_r.addr_lo),
    .wbsel  (hold_r.wbsel),
    .data   (align_s)
  );

  // Retire source: the held op on a dmem response, otherwise the op being accepted.
  always_comb begin
    if (state_r == WAIT) begin
      ret_go_s   = dmem_resp;
      ret_trap_s = 1'b0;
      ret_hold_s = hold_r;
      ret_data_s = (hold_r.opcode == OP_B_LOAD) ? align_s
                                                : src_data(hold_r.wbsel, result_r, hold_r.pc);
    end else begin
      ret_go_s   = accept_s && !in_wait_s;
      ret_trap_s = in_trap_s;
      ret_hold_s = in_hold_s;
      ret_data_s = src_data(mem.in_wbsel, mem.in_result, mem.in_pc);
    end
  end

  // FSM with registered retire outputs and bookkeeping counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= EMPTY;
      hold_r     <= '0;
      result_r   <= '0;
      rf_we_r    <= 1'b0;
      rf_rd_r    <= 5'd0;
      rf_wdata_r <= '0;
      commit_r   <= 1'b0;
      trap_r     <= 1'b0;
      order_r    <= '0;
      stall_r    <= '0;
      resp_err_r <= 1'b0;
    end else begin
      rf_we_r  <= 1'b0;
      commit_r <= 1'b0;
      trap_r   <= 1'b0;
      if (dmem_resp && (state_r != WAIT)) begin
        resp_err_r <= 1'b1;
      end
      if ((state_r == WAIT) && !dmem_resp && (stall_r != {STALL_W{1'b1}})) begin
        stall_r <= stall_r + STALL_W'(1'b1);
      end
      if (ret_go_s) begin
        rf_we_r    <= ret_hold_s.regf_we && (ret_hold_s.rd != 5'd0) && !ret_trap_s;
        rf_rd_r    <= ret_hold_s.rd;
        rf_wdata_r <= ret_data_s;
        commit_r   <= !ret_trap_s;
        trap_r     <= ret_trap_s;
        if (!ret_trap_s) begin
          order_r <= order_r + ORDER_W'(1'b1);
        end
      end
      case (state_r)
        EMPTY, RETIRE: begin
          if (accept_s) begin
            hold_r   <= in_hold_s;
            result_r <= mem.in_result;
            state_r  <= in_wait_s ? WAIT : RETIRE;
          end else begin
            state_r <= EMPTY;
          end
        end
        WAIT: begin
          state_r <= dmem_resp ? RETIRE : WAIT;
        end
        default: state_r <= EMPTY;
      endcase
    end
  end

  assign rf_we         = rf_we_r;
  assign rf_rd         = rf_rd_r;
  assign rf_wdata      = rf_wdata_r;
  assign commit        = commit_r;
  assign order         = order_r;
  assign stall_cnt     = stall_r;
  assign trap_misalign = trap_r;
  assign resp_err      = resp_err_r;

endmodule

// File: tb/tb_wb_retire_unit.sv
// Directed bench for wb_retire_unit: a 32-bit and a 64-bit instance, hand-computed expectations.
module tb_wb_retire_unit;
  import wb_retire_unit_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  wb_retire_unit_if #(.XLEN(32)) if32 ();
  wb_retire_unit_if #(.XLEN(64)) if64 ();

  logic        resp32, resp64;
  logic [31:0] rdata32;
  logic [63:0] rdata64;

  logic        we32, commit32, trap32, err32;
  logic [4:0]  rd32;
  logic [31:0] wdata32;
  logic [63:0] order32;
  logic [31:0] stall32;

  logic        we64, commit64, trap64, err64;
  logic [4:0]  rd64;
  logic [63:0] wdata64;
  logic [63:0] order64;
  logic [31:0] stall64;

  wb_retire_unit #(.XLEN(32)) u32 (
    .clk(clk), .rst(rst), .mem(if32.slave), .dmem_resp(resp32), .dmem_rdata(rdata32),
    .rf_we(we32), .rf_rd(rd32), .rf_wdata(wdata32), .commit(commit32), .order(order32),
    .stall_cnt(stall32), .trap_misalign(trap32), .resp_err(err32)
  );

  wb_retire_unit #(.XLEN(64)) u64 (
    .clk(clk), .rst(rst), .mem(if64.slave), .dmem_resp(resp64), .dmem_rdata(rdata64),
    .rf_we(we64), .rf_rd(rd64), .rf_wdata(wdata64), .commit(commit64), .order(order64),
    .stall_cnt(stall64), .trap_misalign(trap64), .resp_err(err64)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send32(input logic [6:0] op, input wb_sel_t sel, input logic [4:0] rd,
                        input logic [31:0] res, input logic [2:0] a);
    if32.in_valid   = 1'b1;
    if32.in_opcode  = op;
    if32.in_wbsel   = sel;
    if32.in_rd      = rd;
    if32.in_regf_we = 1'b1;
    if32.in_result  = res;
    if32.in_addr_lo = a;
    if32.in_pc      = 32'h0000_0100;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    checks = 0;
    failures = 0;
    resp32 = 1'b0; rdata32 = 32'h0; resp64 = 1'b0; rdata64 = 64'h0;
    if32.in_valid = 1'b0; if32.in_pc = 32'h0; if32.in_opcode = 7'h0; if32.in_rd = 5'd0;
    if32.in_regf_we = 1'b0; if32.in_wbsel = WB_ALU; if32.in_result = 32'h0; if32.in_addr_lo = 3'd0;
    if64.in_valid = 1'b0; if64.in_pc = 32'h0; if64.in_opcode = 7'h0; if64.in_rd = 5'd0;
    if64.in_regf_we = 1'b0; if64.in_wbsel = WB_ALU; if64.in_result = 64'h0; if64.in_addr_lo = 3'd0;
    #1;
    check_eq("rst_ready", 64'(if32.in_ready), 64'd1);
    check_eq("rst_commit", 64'(commit32), 64'd0);
    check_eq("rst_we", 64'(we32), 64'd0);
    check_eq("rst_order", order32, 64'd0);
    check_eq("rst_stall", 64'(stall32), 64'd0);
    check_eq("rst_err", 64'(err32), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // ALU op retires the cycle after accept
    send32(7'b0110011, WB_ALU, 5'd5, 32'h0000_1234, 3'd0);
    tick();
    if32.in_valid = 1'b0;
    check_eq("alu_we", 64'(we32), 64'd1);
    check_eq("alu_rd", 64'(rd32), 64'd5);
    check_eq("alu_wdata", 64'(wdata32), 64'h1234);
    check_eq("alu_commit", 64'(commit32), 64'd1);
    check_eq("alu_order", order32, 64'd1);
    tick();
    check_eq("alu_idle_commit", 64'(commit32), 64'd0);

    // four back-to-back ALU ops
    for (int i = 1; i <= 4; i++) begin
      send32(7'b0110011, WB_ALU, 5'(i), 32'(i * 16), 3'd0);
      check_eq("b2b_ready", 64'(if32.in_ready), 64'd1);
      tick();
      check_eq("b2b_commit", 64'(commit32), 64'd1);
      check_eq("b2b_wdata", 64'(wdata32), 64'(i * 16));
    end
    if32.in_valid = 1'b0;
    check_eq("b2b_order", order32, 64'd5);
    tick();

    // LB at offset 3, response in the third cycle after accept
    send32(OP_B_LOAD, WB_LB, 5'd7, 32'h0, 3'd3);
    tick();
    if32.in_valid = 1'b0;
    check_eq("lb_wait_ready", 64'(if32.in_ready), 64'd0);
    check_eq("lb_wait_commit", 64'(commit32), 64'd0);
    tick();
    check_eq("lb_wait_ready2", 64'(if32.in_ready), 64'd0);
    tick();
    resp32 = 1'b1;
    rdata32 = 32'h80AA_BBCC;
    tick();
    resp32 = 1'b0;
    check_eq("lb_wdata", 64'(wdata32), 64'hFFFF_FF80);
    check_eq("lb_we", 64'(we32), 64'd1);
    check_eq("lb_rd", 64'(rd32), 64'd7);
    check_eq("lb_stall", 64'(stall32), 64'd2);
    check_eq("lb_order", order32, 64'd6);
    check_eq("lb_err", 64'(err32), 64'd0);

    // LH at offset 2 with minimum latency
    send32(OP_B_LOAD, WB_LH, 5'd8, 32'h0, 3'd2);
    tick();
    if32.in_valid = 1'b0;
    resp32 = 1'b1;
    rdata32 = 32'h8001_1234;
    tick();
    resp32 = 1'b0;
    check_eq("lh_wdata", 64'(wdata32), 64'hFFFF_8001);
    check_eq("lh_commit", 64'(commit32), 64'd1);
    check_eq("lh_stall", 64'(stall32), 64'd2);

    // misaligned LH, misaligned SW, illegal LD on 32-bit: all trap, nothing commits
    send32(OP_B_LOAD, WB_LH, 5'd9, 32'h0, 3'd1);
    tick();
    check_eq("lhmis_trap", 64'(trap32), 64'd1);
    check_eq("lhmis_we", 64'(we32), 64'd0);
    check_eq("lhmis_commit", 64'(commit32), 64'd0);
    check_eq("lhmis_ready", 64'(if32.in_ready), 64'd1);
    send32(OP_B_STORE, WB_ALU, 5'd0, 32'h0, 3'd2);
    tick();
    check_eq("swmis_trap", 64'(trap32), 64'd1);
    send32(OP_B_LOAD, WB_LD, 5'd10, 32'h0, 3'd0);
    tick();
    check_eq("ld32_trap", 64'(trap32), 64'd1);
    check_eq("ld32_we", 64'(we32), 64'd0);
    check_eq("trap_order", order32, 64'd7);

    // BR and LINK write sources back to back
    send32(7'b1100011, WB_BR, 5'd11, 32'h0000_0003, 3'd0);
    tick();
    check_eq("br_wdata", 64'(wdata32), 64'd1);
    check_eq("br_trap", 64'(trap32), 64'd0);
    send32(7'b1101111, WB_LINK, 5'd1, 32'hDEAD_0000, 3'd0);
    tick();
    if32.in_valid = 1'b0;
    check_eq("link_wdata", 64'(wdata32), 64'h104);
    check_eq("link_order", order32, 64'd9);
    tick();

    // 64-bit LWU at offset 4
    if64.in_valid = 1'b1; if64.in_opcode = OP_B_LOAD; if64.in_wbsel = WB_LWU;
    if64.in_rd = 5'd3; if64.in_regf_we = 1'b1; if64.in_addr_lo = 3'd4;
    tick();
    if64.in_valid = 1'b0;
    check_eq("lwu64_ready", 64'(if64.in_ready), 64'd0);
    resp64 = 1'b1;
    rdata64 = 64'hDEAD_BEEF_0000_0000;
    tick();
    resp64 = 1'b0;
    check_eq("lwu64_wdata", wdata64, 64'h0000_0000_DEAD_BEEF);
    check_eq("lwu64_commit", 64'(commit64), 64'd1);
    check_eq("lwu64_err", 64'(err64), 64'd0);
    // response in the accepting cycle belongs to nobody
    if64.in_valid = 1'b1; if64.in_opcode = 7'b0110011; if64.in_wbsel = WB_ALU;
    if64.in_result = 64'h1; resp64 = 1'b1;
    tick();
    if64.in_valid = 1'b0; resp64 = 1'b0;
    check_eq("acc_resp_err", 64'(err64), 64'd1);
    check_eq("acc_resp_commit", 64'(commit64), 64'd1);

    // reset mid-WAIT drops the held load; stray response flags resp_err
    send32(OP_B_LOAD, WB_LW, 5'd4, 32'h0, 3'd0);
    tick();
    if32.in_valid = 1'b0;
    check_eq("midwait_ready", 64'(if32.in_ready), 64'd0);
    rst = 1'b0;
    #2;
    check_eq("midrst_ready", 64'(if32.in_ready), 64'd1);
    check_eq("midrst_order", order32, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    resp32 = 1'b1;
    rdata32 = 32'h1111_2222;
    tick();
    resp32 = 1'b0;
    check_eq("stray_commit", 64'(commit32), 64'd0);
    check_eq("stray_order", order32, 64'd0);
    check_eq("stray_err", 64'(err32), 64'd1);
    send32(7'b0110011, WB_ALU, 5'd0, 32'h55, 3'd0);
    tick();
    if32.in_valid = 1'b0;
    check_eq("rd0_commit", 64'(commit32), 64'd1);
    check_eq("rd0_we", 64'(we32), 64'd0);
    check_eq("rd0_order", order32, 64'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
